// File: rtl/hub75_scan_driver_if.sv
// Frame-memory read bus between the HUB75 scan driver and a dual-half frame RAM.
//   rd_addr    : {buffer, row, column} read address (driver -> memory)
//   rd_data_hi : pixel for the upper panel half, {R, G, B} (memory -> driver)
//   rd_data_lo : pixel for the lower panel half, same format (memory -> driver)
// The master modport is the scan driver; the slave modport is the frame memory.
interface hub75_scan_driver_if #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 24
);
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data_hi;
  logic [DW-1:0] rd_data_lo;

  modport master (output rd_addr, input rd_data_hi, input rd_data_lo);
  modport slave  (input rd_addr, output rd_data_hi, output rd_data_lo);
endinterface

// File: rtl/hub75_scan_driver.sv
// HUB75 1/16-scan panel driver with binary-code modulation.
// Walks every row and bit plane of the selected frame buffer, fetching one column from each panel
// half per shift, then blanks, latches and lights the row for BASE_TIME<<plane cycles.
//   clk, reset_n   : clock and synchronous active-low reset
//   enable         : run frames; when dropped, the current plane finishes and the driver idles
//   disp_buffer    : buffer to display, sampled only at frame start
//   mem            : frame-memory read bus (rd_addr out, rd_data_hi/rd_data_lo in)
//   r1,g1,b1       : upper-half colour bits for the current plane
//   r2,g2,b2       : lower-half colour bits for the current plane
//   row_addr       : panel A-D row select
//   sclk, lat, oe_n: panel shift clock, latch strobe, active-low output enable
//   frame_done     : one-cycle pulse after the last plane of the last row
module hub75_scan_driver #(
  parameter int unsigned COLS       = 64,
  parameter int unsigned ROWS       = 16,
  parameter int unsigned PLANES     = 8,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned BASE_TIME  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    disp_buffer,
  hub75_scan_driver_if.master     mem,
  output logic                    r1,
  output logic                    g1,
  output logic                    b1,
  output logic                    r2,
  output logic                    g2,
  output logic                    b2,
  output logic [$clog2(ROWS)-1:0] row_addr,
  output logic                    sclk,
  output logic                    lat,
  output logic                    oe_n,
  output logic                    frame_done
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned PW = $clog2(PLANES);
  localparam int unsigned IW = $clog2(3 * PLANES);
  // One timer serves both the fetch wait and the longest display period.
  localparam int unsigned TW = $clog2((BASE_TIME << (PLANES - 1)) + 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StShiftLo, StShiftHi, StBlank, StLatch, StDisplay
  } state_e;

  state_e          state_q, state_d;
  logic            buf_q, buf_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [PW-1:0]   plane_q, plane_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [RW-1:0]   row_addr_q, row_addr_d;
  logic            frame_done_q, frame_done_d;
  logic            sclk_q, lat_q, oe_n_q;
  logic            frame_end;
  logic [TW-1:0]   disp_len;
  logic            shifting;
  logic [IW-1:0]   idx_r, idx_g, idx_b;

  assign disp_len = TW'(BASE_TIME) << plane_q;

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    row_d        = row_q;
    col_d        = col_q;
    plane_d      = plane_q;
    tmr_d        = tmr_q;
    row_addr_d   = row_addr_q;
    frame_done_d = 1'b0;
    frame_end    = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable) begin
          buf_d   = disp_buffer;
          row_d   = '0;
          col_d   = '0;
          plane_d = '0;
          tmr_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (tmr_q == TW'(RD_LATENCY - 1)) state_d = StShiftLo;
        else                              tmr_d   = tmr_q + 1'b1;
      end
      StShiftLo: state_d = StShiftHi;
      StShiftHi: begin
        if (col_q == CW'(COLS - 1)) begin
          state_d = StBlank;
        end else begin
          col_d   = col_q + 1'b1;
          tmr_d   = '0;
          state_d = StFetch;
        end
      end
      StBlank: begin
        // Row select moves only while the panel is dark.
        row_addr_d = row_q;
        state_d    = StLatch;
      end
      StLatch: begin
        tmr_d   = '0;
        state_d = StDisplay;
      end
      StDisplay: begin
        if (tmr_q == disp_len - 1'b1) begin
          tmr_d = '0;
          col_d = '0;
          if (plane_q != PW'(PLANES - 1)) begin
            plane_d = plane_q + 1'b1;
          end else begin
            plane_d = '0;
            if (row_q != RW'(ROWS - 1)) begin
              row_d = row_q + 1'b1;
            end else begin
              row_d        = '0;
              frame_done_d = 1'b1;
              frame_end    = 1'b1;
            end
          end
          if (!enable) begin
            state_d = StIdle;
          end else begin
            state_d = StFetch;
            // Buffer swaps only at frame boundaries to avoid tearing.
            if (frame_end) buf_d = disp_buffer;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      buf_q        <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      plane_q      <= '0;
      tmr_q        <= '0;
      row_addr_q   <= '0;
      frame_done_q <= 1'b0;
      sclk_q       <= 1'b0;
      lat_q        <= 1'b0;
      oe_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      row_q        <= row_d;
      col_q        <= col_d;
      plane_q      <= plane_d;
      tmr_q        <= tmr_d;
      row_addr_q   <= row_addr_d;
      frame_done_q <= frame_done_d;
      // Panel strobes are registered from the next state so they track state_q glitch-free.
      sclk_q       <= (state_d == StShiftHi);
      lat_q        <= (state_d == StLatch);
      oe_n_q       <= (state_d != StDisplay);
    end
  end

  assign mem.rd_addr = {buf_q, row_q, col_q};

  // Memory data is valid from SHIFT_LO and held through SHIFT_HI, so the colour bits are
  // stable a full cycle before sclk rises.
  assign shifting = (state_q == StShiftLo) || (state_q == StShiftHi);
  assign idx_b    = IW'(plane_q);
  assign idx_g    = IW'(PLANES) + IW'(plane_q);
  assign idx_r    = IW'(2 * PLANES) + IW'(plane_q);

  assign r1 = shifting & mem.rd_data_hi[idx_r];
  assign g1 = shifting & mem.rd_data_hi[idx_g];
  assign b1 = shifting & mem.rd_data_hi[idx_b];
  assign r2 = shifting & mem.rd_data_lo[idx_r];
  assign g2 = shifting & mem.rd_data_lo[idx_g];
  assign b2 = shifting & mem.rd_data_lo[idx_b];

  assign row_addr   = row_addr_q;
  assign sclk       = sclk_q;
  assign lat        = lat_q;
  assign oe_n       = oe_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_driver.sv
module tb_hub75_scan_driver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       disp_buffer;
  logic       r1, g1, b1, r2, g2, b2;
  logic [3:0] row_addr;
  logic       sclk, lat, oe_n, frame_done;

  int vectors = 0;
  int miscompares = 0;

  hub75_scan_driver_if mem_if ();

  hub75_scan_driver dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .disp_buffer(disp_buffer),
    .mem        (mem_if.master),
    .r1         (r1),
    .g1         (g1),
    .b1         (b1),
    .r2         (r2),
    .g2         (g2),
    .b2         (b2),
    .row_addr   (row_addr),
    .sclk       (sclk),
    .lat        (lat),
    .oe_n       (oe_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Frame memory model: registered address then registered data (two-cycle latency).
  logic [23:0] mem_hi [2048];
  logic [23:0] mem_lo [2048];
  logic [10:0] addr_r;
  always @(posedge clk) begin
    addr_r            <= mem_if.rd_addr;
    mem_if.rd_data_hi <= mem_hi[addr_r];
    mem_if.rd_data_lo <= mem_lo[addr_r];
  end

  // Panel-side monitor, sampled on the falling edge.
  logic [10:0] addr_q [$];
  logic [5:0]  pix_q [$];
  int          widths [$];
  logic [3:0]  rows_q [$];
  int sclk_cnt, lat_cnt, fd_cnt, row_viol, buf0_cnt, buf1_cnt, run;
  logic sclk_p = 1'b0, lat_p = 1'b0, oe_p = 1'b1;
  logic [3:0] row_p = 4'd0;

  always @(negedge clk) begin
    if (sclk && !sclk_p) begin
      sclk_cnt++;
      addr_q.push_back(mem_if.rd_addr);
      if (mem_if.rd_addr[5:0] == 6'd0) pix_q.push_back({r1, g1, b1, r2, g2, b2});
      if (mem_if.rd_addr[10]) buf1_cnt++;
      else                    buf0_cnt++;
    end
    if (lat && !lat_p) lat_cnt++;
    if (!oe_n) run++;
    if (!oe_n && oe_p) rows_q.push_back(row_addr);
    if (oe_n && !oe_p) begin
      widths.push_back(run);
      run = 0;
    end
    if (row_addr != row_p && !(oe_n && oe_p)) row_viol++;
    if (frame_done) fd_cnt++;
    sclk_p = sclk;
    lat_p  = lat;
    oe_p   = oe_n;
    row_p  = row_addr;
  end

  task automatic clear_mon();
    addr_q.delete();
    pix_q.delete();
    widths.delete();
    rows_q.delete();
    sclk_cnt = 0; lat_cnt = 0; fd_cnt = 0; row_viol = 0;
    buf0_cnt = 0; buf1_cnt = 0; run = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; disp_buffer = 1'b0;
    tick(5);
    clear_mon();
    vectors++;
    if (oe_n !== 1'b1) begin miscompares++; $display("FAIL reset_oe_n got %b want 1", oe_n); end
    vectors++;
    if (lat !== 1'b0) begin miscompares++; $display("FAIL reset_lat got %b want 0", lat); end
    vectors++;
    if (sclk !== 1'b0) begin miscompares++; $display("FAIL reset_sclk got %b want 0", sclk); end
    vectors++;
    if (mem_if.rd_addr !== 11'h000) begin
      miscompares++; $display("FAIL reset_rd_addr got %h want 000", mem_if.rd_addr);
    end
    vectors++;
    if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    vectors++;
    if ({r1, g1, b1, r2, g2, b2, row_addr} !== 10'd0) begin
      miscompares++; $display("FAIL reset_rgb_row got %b want 0", {r1, g1, b1, r2, g2, b2, row_addr});
    end
    reset_n = 1'b1;
    tick(20);
    vectors++;
    if (sclk_cnt != 0 || lat_cnt != 0 || oe_n !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_hold got sclk=%0d lat=%0d oe_n=%b want 0 0 1", sclk_cnt, lat_cnt, oe_n);
    end
  endtask

  task automatic test_first_plane();
    int n = 0;
    int bad = 0;
    clear_mon();
    disp_buffer = 1'b1;
    enable = 1'b1;
    while (widths.size() < 1 && n < 400) begin tick(1); n++; end
    vectors++;
    if (widths.size() < 1) begin
      miscompares++; $display("FAIL plane0_timeout got no display want one");
    end else begin
      vectors++;
      if (widths[0] != 8) begin miscompares++; $display("FAIL plane0_oe_width got %0d want 8", widths[0]); end
    end
    vectors++;
    if (sclk_cnt != 64) begin miscompares++; $display("FAIL plane0_sclk got %0d want 64", sclk_cnt); end
    vectors++;
    if (lat_cnt != 1) begin miscompares++; $display("FAIL plane0_lat got %0d want 1", lat_cnt); end
    for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != 11'(12'h400 + i)) bad++;
    vectors++;
    if (addr_q.size() != 64 || bad != 0) begin
      miscompares++;
      $display("FAIL plane0_addr_seq got size=%0d bad=%0d want 64 0", addr_q.size(), bad);
    end
  endtask

  task automatic test_pixel_bits();
    int n = 0;
    int bad = 0;
    while (widths.size() < 8 && n < 5000) begin tick(1); n++; end
    vectors++;
    if (pix_q.size() < 8) begin
      miscompares++; $display("FAIL pix_timeout got %0d planes want 8", pix_q.size());
    end else begin
      vectors++;
      if (pix_q[0] !== 6'b101011) begin miscompares++; $display("FAIL pix_plane0 got %b want 101011", pix_q[0]); end
      vectors++;
      if (pix_q[1] !== 6'b001110) begin miscompares++; $display("FAIL pix_plane1 got %b want 001110", pix_q[1]); end
      vectors++;
      if (pix_q[7] !== 6'b100011) begin miscompares++; $display("FAIL pix_plane7 got %b want 100011", pix_q[7]); end
    end
    for (int p = 0; p < widths.size() && p < 8; p++) if (widths[p] != (8 << p)) bad++;
    vectors++;
    if (widths.size() < 8 || bad != 0) begin
      miscompares++; $display("FAIL row0_widths got size=%0d bad=%0d want 8 0", widths.size(), bad);
    end
  endtask

  task automatic test_full_frame();
    int n = 0;
    int bad_w = 0;
    int bad_r = 0;
    bit toggled = 1'b0;
    while (fd_cnt == 0 && n < 70000) begin
      tick(1); n++;
      if (!toggled && widths.size() >= 40) begin disp_buffer = 1'b0; toggled = 1'b1; end
    end
    vectors++;
    if (fd_cnt == 0) begin miscompares++; $display("FAIL frame_timeout got no frame_done want 1"); end
    tick(1);
    vectors++;
    if (fd_cnt != 1 || frame_done !== 1'b0) begin
      miscompares++; $display("FAIL frame_done_pulse got cnt=%0d now=%b want 1 0", fd_cnt, frame_done);
    end
    for (int k = 0; k < widths.size(); k++) if (widths[k] != (8 << (k % 8))) bad_w++;
    vectors++;
    if (widths.size() != 128 || bad_w != 0) begin
      miscompares++; $display("FAIL frame_widths got size=%0d bad=%0d want 128 0", widths.size(), bad_w);
    end
    for (int k = 0; k < rows_q.size(); k++) if (rows_q[k] != 4'(k / 8)) bad_r++;
    vectors++;
    if (rows_q.size() != 128 || bad_r != 0) begin
      miscompares++; $display("FAIL frame_rows got size=%0d bad=%0d want 128 0", rows_q.size(), bad_r);
    end
    vectors++;
    if (row_viol != 0) begin miscompares++; $display("FAIL row_change_lit got %0d want 0", row_viol); end
    vectors++;
    if (sclk_cnt != 8192 || buf1_cnt != 8192) begin
      miscompares++; $display("FAIL frame_buf1 got sclk=%0d buf1=%0d want 8192 8192", sclk_cnt, buf1_cnt);
    end
    clear_mon();
    n = 0;
    while (sclk_cnt == 0 && n < 20) begin tick(1); n++; end
    vectors++;
    if (addr_q.size() == 0) begin
      miscompares++; $display("FAIL next_frame_timeout got no sclk want one");
    end else if (addr_q[0] !== 11'h000) begin
      miscompares++; $display("FAIL next_frame_addr got %h want 000", addr_q[0]);
    end
  endtask

  task automatic test_enable_drop();
    int n = 0;
    int s, l;
    while (widths.size() < 3 && n < 2000) begin tick(1); n++; end
    tick(20);
    enable = 1'b0;
    n = 0;
    while (widths.size() < 4 && n < 2000) begin tick(1); n++; end
    vectors++;
    if (widths.size() < 4) begin
      miscompares++; $display("FAIL drop_timeout got %0d planes want 4", widths.size());
    end else if (widths[3] != 64) begin
      miscompares++; $display("FAIL drop_plane3_width got %0d want 64", widths[3]);
    end
    s = sclk_cnt;
    l = lat_cnt;
    vectors++;
    if (s != 256) begin miscompares++; $display("FAIL drop_sclk_total got %0d want 256", s); end
    tick(300);
    vectors++;
    if (sclk_cnt != s || lat_cnt != l || widths.size() != 4 || oe_n !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_idle got sclk=%0d lat=%0d planes=%0d oe_n=%b want %0d %0d 4 1",
               sclk_cnt, lat_cnt, widths.size(), oe_n, s, l);
    end
  endtask

  task automatic test_reset_mid_shift();
    int n = 0;
    disp_buffer = 1'b1;
    enable = 1'b1;
    tick(1);
    while (!(sclk === 1'b1 && sclk_cnt >= 3) && n < 200) begin tick(1); n++; end
    vectors++;
    if (sclk !== 1'b1) begin miscompares++; $display("FAIL mid_shift_timeout got sclk=%b want 1", sclk); end
    reset_n = 1'b0;
    tick(1);
    vectors++;
    if (sclk !== 1'b0 || oe_n !== 1'b1 || lat !== 1'b0 || mem_if.rd_addr !== 11'h000) begin
      miscompares++;
      $display("FAIL mid_reset got sclk=%b oe_n=%b lat=%b addr=%h want 0 1 0 000",
               sclk, oe_n, lat, mem_if.rd_addr);
    end
    reset_n = 1'b1;
    n = 0;
    while (sclk !== 1'b1 && n < 20) begin tick(1); n++; end
    vectors++;
    if (n != 4 || mem_if.rd_addr !== 11'h400) begin
      miscompares++;
      $display("FAIL restart got cycles=%0d addr=%h want 4 400", n, mem_if.rd_addr);
    end
  endtask

  initial begin
    logic [10:0] a;
    for (int i = 0; i < 2048; i++) begin
      a = 11'(i);
      mem_hi[i] = {a[7:0] ^ 8'h3C, a[10:3], ~a[7:0]};
      mem_lo[i] = {~a[7:0], a[7:0] ^ 8'h96, a[10:3]};
    end
    mem_hi[11'h400] = 24'hA53C0F;
    mem_lo[11'h400] = 24'h5AC381;
    clear_mon();
    test_reset();
    test_first_plane();
    test_pixel_bits();
    test_full_frame();
    test_enable_drop();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
